fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, meaning source operands checked per issued instruction (1..4).
REQ-002 SHALL have parameter FWD_DEPTH, default 2, meaning in-flight stages tracked past EX (1..7); stage 1 = MEM, stage 2 = WB.
REQ-003 SHALL have parameter LOAD_LAT, default 1, meaning a load's data becomes forwardable only at stage index > LOAD_LAT (0..FWD_DEPTH-1).
REQ-004 SHALL have parameter REG_AW, default 5, meaning register address width; SELW = clog2(FWD_DEPTH+1) is derived, not overridable.
REQ-005 SHALL have port Clock, input, 1, sole clock, all state on rising edge.
REQ-006 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port IssueValid, input, 1, instruction present in EX this cycle.
REQ-008 SHALL have port IssueWrEn, input, 1, EX instruction writes a register.
REQ-009 SHALL have port IssueIsLoad, input, 1, EX instruction is a load.
REQ-010 SHALL have port IssueDest, input, REG_AW, EX destination register.
REQ-011 SHALL have port SrcReg, input, NUM_SRC*REG_AW, source registers, operand i in slice i.
REQ-012 SHALL have port SrcUsed, input, NUM_SRC, operand i actually read (replaces opcode decode).
REQ-013 SHALL have port Flush, input, 1, kill all tracked in-flight entries.
REQ-014 SHALL have port FwdSel, output, NUM_SRC*SELW, per-operand mux select: 0 = no forward, k = forward from stage k.
REQ-015 SHALL have port Stall, output, 1, load-use hazard; upstream holds EX instruction and inputs.
REQ-016 SHALL have port StallCount, output, 16, saturating count of stall cycles.

Function
REQ-017 SHALL keep a tracker of FWD_DEPTH entries {valid, wren, is_load, dest}; every cycle entry k moves to k+1, oldest discarded.
REQ-018 SHALL load stage 1 with the EX instruction when IssueValid=1 and Stall=0, else with a bubble (valid=0).
REQ-019 SHALL, on Flush=1, clear all valid bits at the edge; Flush overrides the stage-1 push; Flush does not alter StallCount.
REQ-020 SHALL combinationally match operand i against entries with valid=1, wren=1, dest==SrcReg[i], dest!=0, SrcUsed[i]=1.
REQ-021 SHALL select the youngest (lowest k) matching entry; older matches are never used when a younger one exists.
REQ-022 SHALL flag operand i as hazard when its selected entry has is_load=1 and k<=LOAD_LAT; no fallback to an older entry.
REQ-023 SHALL assert Stall = IssueValid AND any operand hazard; LOAD_LAT=0 never stalls.
REQ-024 SHALL drive FwdSel[i]=k of the selected entry, 0 if none, and all FwdSel=0 while Stall=1.
REQ-025 SHALL ignore Src inputs when IssueValid=0 (FwdSel=0, Stall=0).
REQ-026 SHALL increment StallCount each cycle Stall=1, holding at 16'hFFFF.
REQ-027 SHALL allow Stall for multiple consecutive cycles only when LOAD_LAT>1; stall releases once the load passes stage LOAD_LAT.

Reset
REQ-028 SHALL, on Reset=1 at an edge, clear all tracker valid bits and StallCount to 0; Reset beats Flush and push.
REQ-029 SHALL present FwdSel=0 and Stall=0 in the cycle after reset until a valid entry is pushed.

Structure
REQ-030 SHALL place FWD_NONE=0, the tracker entry typedef and SELW function in shared package fwd_pkg.
REQ-031 SHALL use one sub-module fwd_src_match (priority match + hazard flag for one operand), instantiated NUM_SRC times.
REQ-032 SHALL keep the tracker and StallCount in the top module; no other state.

Verification
REQ-033 SHALL test ALU chain: issue add r3 (wren), next cycle issue SrcReg0=r3 -> FwdSel0=1, Stall=0.
REQ-034 SHALL test two-back: add r3, unrelated, then use r3 in Src1 -> FwdSel1=2.
REQ-035 SHALL test youngest wins: add r4, add r4, use r4 -> FwdSel0=1, not 2.
REQ-036 SHALL test load-use (LOAD_LAT=1): lw r5, next cycle use r5 -> Stall=1 one cycle, FwdSel=0, StallCount=1; next cycle FwdSel0=2, Stall=0.
REQ-037 SHALL test r0 and Flush: dest r0 then use r0 -> FwdSel=0; add r6, Flush, use r6 -> FwdSel=0.
REQ-038 SHALL test Reset mid-stall during lw hazard -> next cycle Stall=0, StallCount=0, tracker empty.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard unit: tracker entry
// layout and the forward-select width function.
package fwd_pkg;
  localparam int FWD_NONE  = 0;
  localparam int DEST_MAXW = 16;

  // dest is stored zero-extended, so one entry type serves any REG_AW <= DEST_MAXW
  typedef struct packed {
    logic                 valid;
    logic                 wren;
    logic                 is_load;
    logic [DEST_MAXW-1:0] dest;
  } trk_entry_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Issue-side bundle of the forwarding unit: EX instruction in, forward selects
// and stall status out.
interface fwd_hazard_unit_if
  import fwd_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int SELW    = 2
);
  logic                      IssueValid;
  logic                      IssueWrEn;
  logic                      IssueIsLoad;
  logic [REG_AW-1:0]         IssueDest;
  logic [NUM_SRC*REG_AW-1:0] SrcReg;
  logic [NUM_SRC-1:0]        SrcUsed;
  logic                      Flush;
  logic [NUM_SRC*SELW-1:0]   FwdSel;
  logic                      Stall;
  logic [15:0]               StallCount;

  modport master (
    output IssueValid, IssueWrEn, IssueIsLoad, IssueDest, SrcReg, SrcUsed, Flush,
    input  FwdSel, Stall, StallCount
  );
  modport slave (
    input  IssueValid, IssueWrEn, IssueIsLoad, IssueDest, SrcReg, SrcUsed, Flush,
    output FwdSel, Stall, StallCount
  );
endinterface

// File: rtl/fwd_src_match.sv
// One source operand: youngest-first match against the tracker plus the
// load-use hazard flag for that match.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int SELW      = 2
) (
  input  trk_entry_t [FWD_DEPTH-1:0] trk_i,
  input  logic [DEST_MAXW-1:0]       src_i,
  input  logic                       used_i,
  output logic [SELW-1:0]            sel_o,
  output logic                       hazard_o
);
  logic found;

  // Index 0 is stage 1 (MEM); the first hit is the youngest producer.
  always_comb begin
    sel_o    = '0;
    hazard_o = 1'b0;
    found    = 1'b0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      if (!found && used_i && trk_i[k].valid && trk_i[k].wren &&
          trk_i[k].dest == src_i && trk_i[k].dest != '0) begin
        found    = 1'b1;
        sel_o    = SELW'(k + 1);
        hazard_o = trk_i[k].is_load && ((k + 1) <= LOAD_LAT);
      end
    end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall unit: tracks in-flight writers past EX
// and picks a forward source per operand.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int  NUM_SRC   = 2,
  parameter int  FWD_DEPTH = 2,
  parameter int  LOAD_LAT  = 1,
  parameter int  REG_AW    = 5,
  localparam int SELW      = sel_w(FWD_DEPTH)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      IssueValid,
  input  logic                      IssueWrEn,
  input  logic                      IssueIsLoad,
  input  logic [REG_AW-1:0]         IssueDest,
  input  logic [NUM_SRC*REG_AW-1:0] SrcReg,
  input  logic [NUM_SRC-1:0]        SrcUsed,
  input  logic                      Flush,
  output logic [NUM_SRC*SELW-1:0]   FwdSel,
  output logic                      Stall,
  output logic [15:0]               StallCount
);
  trk_entry_t [FWD_DEPTH-1:0]     trk_q, trk_d;
  logic [15:0]                    stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0][SELW-1:0]   sel;
  logic [NUM_SRC-1:0]             haz;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_match #(
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_LAT  (LOAD_LAT),
      .SELW      (SELW)
    ) u_match (
      .trk_i    (trk_q),
      .src_i    (DEST_MAXW'(SrcReg[g*REG_AW +: REG_AW])),
      .used_i   (SrcUsed[g] & IssueValid),
      .sel_o    (sel[g]),
      .hazard_o (haz[g])
    );
    assign FwdSel[g*SELW +: SELW] = Stall ? SELW'(FWD_NONE) : sel[g];
  end

  assign Stall      = IssueValid & (|haz);
  assign StallCount = stall_cnt_q;

  // A stalled EX instruction is held upstream, so it enters the tracker as a bubble.
  always_comb begin
    trk_d    = '0;
    trk_d[0] = '0;
    if (IssueValid && !Stall) begin
      trk_d[0].valid   = 1'b1;
      trk_d[0].wren    = IssueWrEn;
      trk_d[0].is_load = IssueIsLoad;
      trk_d[0].dest    = DEST_MAXW'(IssueDest);
    end
    for (int k = 1; k < FWD_DEPTH; k++) trk_d[k] = trk_q[k-1];
    if (Flush) begin
      for (int k = 0; k < FWD_DEPTH; k++) trk_d[k].valid = 1'b0;
    end
    stall_cnt_d = (Stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      trk_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      trk_q       <= trk_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: expected outputs are queued as each
// cycle is driven and checked against the DUT mid-cycle.
module tb_fwd_hazard_unit;
  import fwd_pkg::*;

  localparam int NUM_SRC = 2;
  localparam int REG_AW  = 5;
  localparam int SELW    = sel_w(2);

  typedef struct {
    logic [SELW-1:0] s0;
    logic [SELW-1:0] s1;
    logic            st;
    logic [15:0]     cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  exp_t sb[$];

  fwd_hazard_unit_if #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .SELW(SELW)) bus ();

  fwd_hazard_unit #(
    .NUM_SRC(NUM_SRC), .FWD_DEPTH(2), .LOAD_LAT(1), .REG_AW(REG_AW)
  ) dut (
    .Clock       (clk),
    .Reset       (rst),
    .IssueValid  (bus.IssueValid),
    .IssueWrEn   (bus.IssueWrEn),
    .IssueIsLoad (bus.IssueIsLoad),
    .IssueDest   (bus.IssueDest),
    .SrcReg      (bus.SrcReg),
    .SrcUsed     (bus.SrcUsed),
    .Flush       (bus.Flush),
    .FwdSel      (bus.FwdSel),
    .Stall       (bus.Stall),
    .StallCount  (bus.StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive after the edge, queue expectation, compare at the falling edge.
  task automatic cyc(input string tag, input logic r, input logic v, input logic we,
                     input logic ld, input logic [4:0] dst, input logic [4:0] s0,
                     input logic [4:0] s1, input logic [1:0] used, input logic fl,
                     input logic [1:0] e0, input logic [1:0] e1, input logic est,
                     input logic [15:0] ecnt);
    exp_t e;
    exp_t got;
    @(posedge clk);
    #1;
    rst             = r;
    bus.IssueValid  = v;
    bus.IssueWrEn   = we;
    bus.IssueIsLoad = ld;
    bus.IssueDest   = dst;
    bus.SrcReg      = {s1, s0};
    bus.SrcUsed     = used;
    bus.Flush       = fl;
    e.s0 = e0; e.s1 = e1; e.st = est; e.cnt = ecnt;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    chk({tag, ".sel0"},  16'(bus.FwdSel[SELW-1:0]),      16'(got.s0));
    chk({tag, ".sel1"},  16'(bus.FwdSel[2*SELW-1:SELW]), 16'(got.s1));
    chk({tag, ".stall"}, 16'(bus.Stall),                  16'(got.st));
    chk({tag, ".cnt"},   bus.StallCount,                  got.cnt);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.IssueValid = 0; bus.IssueWrEn = 0; bus.IssueIsLoad = 0; bus.IssueDest = '0;
    bus.SrcReg = '0; bus.SrcUsed = '0; bus.Flush = 0;
    repeat (2) @(posedge clk);

    //   tag          r  v  we ld dst s0 s1 used fl  e0 e1 st cnt
    cyc("reset",      0, 0, 0, 0, 0,  0, 0, 2'b00, 0, 0, 0, 0, 0);
    cyc("add_r3",     0, 1, 1, 0, 3,  1, 2, 2'b11, 0, 0, 0, 0, 0);
    cyc("alu_chain",  0, 1, 1, 0, 7,  3, 0, 2'b01, 0, 1, 0, 0, 0);
    cyc("unrelated",  0, 1, 1, 0, 8,  9, 10, 2'b11, 0, 0, 0, 0, 0);
    cyc("two_back",   0, 1, 1, 0, 4,  0, 7, 2'b10, 0, 0, 2, 0, 0);
    cyc("add_r4b",    0, 1, 1, 0, 4,  4, 4, 2'b00, 0, 0, 0, 0, 0);
    cyc("youngest",   0, 1, 0, 0, 0,  4, 4, 2'b11, 0, 1, 1, 0, 0);
    cyc("lw_r5",      0, 1, 1, 1, 5,  0, 0, 2'b00, 0, 0, 0, 0, 0);
    cyc("ld_use",     0, 1, 1, 0, 9,  5, 0, 2'b01, 0, 0, 0, 1, 0);
    cyc("ld_release", 0, 1, 1, 0, 9,  5, 0, 2'b01, 0, 2, 0, 0, 1);
    cyc("dest_r0",    0, 1, 1, 0, 0,  0, 0, 2'b00, 0, 0, 0, 0, 1);
    cyc("use_r0",     0, 1, 1, 0, 6,  0, 0, 2'b11, 0, 0, 0, 0, 1);
    cyc("idle_src",   0, 0, 0, 0, 0,  6, 6, 2'b11, 1, 0, 0, 0, 1);
    cyc("post_flush", 0, 1, 0, 0, 0,  6, 6, 2'b11, 0, 0, 0, 0, 1);
    cyc("lw_r5b",     0, 1, 1, 1, 5,  0, 0, 2'b00, 0, 0, 0, 0, 1);
    cyc("rst_stall",  1, 1, 1, 0, 9,  5, 5, 2'b11, 0, 0, 0, 1, 1);
    cyc("after_rst",  0, 1, 1, 0, 9,  5, 5, 2'b11, 0, 0, 0, 0, 0);
    cyc("empty_trk",  0, 1, 0, 0, 0,  9, 5, 2'b11, 0, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
